// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg
// Shared constants for the DSP48A1 slice model: default datapath widths,
// OPMODE bit positions and the X/Z operand-select encodings.
// No ports (package).
package dsp48a1_pkg;

  localparam int DEFAULT_WIDTH_P = 48;
  localparam int DEFAULT_WIDTH_M = 36;

  // OPMODE as seen by the post-adder: {bit7, bit3:2, bit1:0} packed into 5 bits
  localparam int OPMODE_W     = 5;
  localparam int OPMODE_SUB   = 4;
  localparam int OPMODE_Z_MSB = 3;
  localparam int OPMODE_Z_LSB = 2;
  localparam int OPMODE_X_MSB = 1;
  localparam int OPMODE_X_LSB = 0;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

  // True when either operand mux routes the P register back into the adder
  function automatic logic uses_feedback(input logic [OPMODE_W-1:0] op);
    return (op[OPMODE_X_MSB:OPMODE_X_LSB] == X_P) ||
           (op[OPMODE_Z_MSB:OPMODE_Z_LSB] == Z_P);
  endfunction

endpackage

// File: rtl/dsp48a1_reg_mux.sv
// dsp48a1_reg_mux
// Generic slice pipeline cell: an optional register with clock enable and
// reset, or a straight wire when REG = 0.
// Ports:
//   clk  - clock, rising edge
//   rstn - active-low reset (async or sync per RST_TYPE)
//   ce   - clock enable
//   d    - data in
//   q    - registered (REG = 1) or bypassed (REG = 0) data out
module dsp48a1_reg_mux #(
  parameter int    WIDTH    = 1,
  parameter int    REG      = 1,
  parameter string RST_TYPE = "ASYNC"
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (REG == 0) begin : g_bypass
      assign q = d;
    end else if (RST_TYPE == "ASYNC") begin : g_async
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   q <= '0;
        else if (ce) q <= d;
      end
    end else begin : g_sync
      always_ff @(posedge clk) begin
        if (!rstn)   q <= '0;
        else if (ce) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/dsp_post_adder_acc_post_add_core.sv
// post_add_core
// Purely combinational X/Z operand muxes and the (WIDTH_P+1)-bit
// add/subtract of the DSP48A1 post-adder.
// Ports:
//   opmode - {sub, Z sel[1:0], X sel[1:0]}
//   cin    - carry-in
//   m      - multiplier product (zero-extended onto the X leg)
//   dab    - {D, A, B} concatenation
//   c      - C operand
//   pcin   - cascade input
//   p_fb   - P feedback (already forced to 0 when P is not registered)
//   r      - {carry/borrow, result}
module post_add_core
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH_P = DEFAULT_WIDTH_P,
  parameter int WIDTH_M = DEFAULT_WIDTH_M
) (
  input  logic [OPMODE_W-1:0] opmode,
  input  logic                cin,
  input  logic [WIDTH_M-1:0]  m,
  input  logic [WIDTH_P-1:0]  dab,
  input  logic [WIDTH_P-1:0]  c,
  input  logic [WIDTH_P-1:0]  pcin,
  input  logic [WIDTH_P-1:0]  p_fb,
  output logic [WIDTH_P:0]    r
);

  logic [WIDTH_P-1:0] x_op;
  logic [WIDTH_P-1:0] z_op;
  logic [WIDTH_P:0]   x_plus_cin;

  always_comb begin
    x_op = '0;
    unique case (x_sel_e'(opmode[OPMODE_X_MSB:OPMODE_X_LSB]))
      X_ZERO:  x_op = '0;
      X_M:     x_op = {{(WIDTH_P-WIDTH_M){1'b0}}, m};
      X_P:     x_op = p_fb;
      X_DAB:   x_op = dab;
      default: x_op = '0;
    endcase
  end

  always_comb begin
    z_op = '0;
    unique case (z_sel_e'(opmode[OPMODE_Z_MSB:OPMODE_Z_LSB]))
      Z_ZERO:  z_op = '0;
      Z_PCIN:  z_op = pcin;
      Z_P:     z_op = p_fb;
      Z_C:     z_op = c;
      default: z_op = '0;
    endcase
  end

  // CIN joins the X leg, so subtraction is Z - (X + CIN). Computing one bit
  // wider makes the top bit the carry on add and the borrow on subtract.
  assign x_plus_cin = {1'b0, x_op} + {{WIDTH_P{1'b0}}, cin};
  assign r = opmode[OPMODE_SUB] ? ({1'b0, z_op} - x_plus_cin)
                                : ({1'b0, z_op} + x_plus_cin);

endmodule

// File: rtl/dsp_post_adder_acc.sv
// dsp_post_adder_acc
// Post-adder/accumulator stage of the DSP48A1 slice: optional OPMODE and
// CIN pipeline registers, the combinational post-adder core, and the
// P/CARRYOUT register with cascade and fabric copies.
// Ports:
//   clk, rstn                 - clock (rising) and async active-low reset
//   CEP, CEOPMODE, CECARRYIN  - clock enables of the P, OPMODE, CIN registers
//   OPMODE[4:0]               - {sub, Z sel, X sel}
//   CARRYIN                   - post-adder carry-in
//   M, DAB, C, PCIN           - operands
//   P, PCOUT                  - result and its cascade copy
//   CARRYOUT, CARRYOUTF       - carry/borrow and its fabric copy
module dsp_post_adder_acc
  import dsp48a1_pkg::*;
#(
  parameter int PREG       = 1,
  parameter int OPMODEREG  = 1,
  parameter int CARRYINREG = 1,
  parameter int WIDTH_P    = DEFAULT_WIDTH_P,
  parameter int WIDTH_M    = DEFAULT_WIDTH_M
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                CEP,
  input  logic                CEOPMODE,
  input  logic                CECARRYIN,
  input  logic [OPMODE_W-1:0] OPMODE,
  input  logic                CARRYIN,
  input  logic [WIDTH_M-1:0]  M,
  input  logic [WIDTH_P-1:0]  DAB,
  input  logic [WIDTH_P-1:0]  C,
  input  logic [WIDTH_P-1:0]  PCIN,
  output logic [WIDTH_P-1:0]  P,
  output logic [WIDTH_P-1:0]  PCOUT,
  output logic                CARRYOUT,
  output logic                CARRYOUTF
);

  logic [OPMODE_W-1:0] opmode_q;
  logic                cin_q;
  logic [WIDTH_P:0]    sum;
  logic [WIDTH_P:0]    p_q;
  logic [WIDTH_P-1:0]  p_fb;

  dsp48a1_reg_mux #(.WIDTH(OPMODE_W), .REG(OPMODEREG), .RST_TYPE("ASYNC")) u_opmode_reg (
    .clk  (clk),
    .rstn (rstn),
    .ce   (CEOPMODE),
    .d    (OPMODE),
    .q    (opmode_q)
  );

  dsp48a1_reg_mux #(.WIDTH(1), .REG(CARRYINREG), .RST_TYPE("ASYNC")) u_cin_reg (
    .clk  (clk),
    .rstn (rstn),
    .ce   (CECARRYIN),
    .d    (CARRYIN),
    .q    (cin_q)
  );

  // Feedback only exists through a real register; without PREG the leg is
  // tied off so no combinational loop is ever built.
  generate
    if (PREG != 0) begin : g_fb
      assign p_fb = p_q[WIDTH_P-1:0];
    end else begin : g_no_fb
      assign p_fb = '0;
      always @(posedge clk) begin
        if (rstn) assert (!uses_feedback(opmode_q));
      end
    end
  endgenerate

  post_add_core #(.WIDTH_P(WIDTH_P), .WIDTH_M(WIDTH_M)) u_core (
    .opmode (opmode_q),
    .cin    (cin_q),
    .m      (M),
    .dab    (DAB),
    .c      (C),
    .pcin   (PCIN),
    .p_fb   (p_fb),
    .r      (sum)
  );

  // P and CARRYOUT share one enable and reset, so they live in one register
  dsp48a1_reg_mux #(.WIDTH(WIDTH_P+1), .REG(PREG), .RST_TYPE("ASYNC")) u_p_reg (
    .clk  (clk),
    .rstn (rstn),
    .ce   (CEP),
    .d    (sum),
    .q    (p_q)
  );

  assign P         = p_q[WIDTH_P-1:0];
  assign CARRYOUT  = p_q[WIDTH_P];
  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// tb_dsp_post_adder_acc
// Bench for dsp_post_adder_acc: one fully registered instance driven as an
// aligned stream (OPMODE/CIN issued a cycle ahead of the operands, as the
// upstream M pipeline would), and one fully bypassed instance.
module tb_dsp_post_adder_acc;
  import dsp48a1_pkg::*;

  localparam int WP = 48;
  localparam int WM = 36;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cep, ceop, cecin;
  logic [4:0]    opmode;
  logic          carryin;
  logic [WM-1:0] m;
  logic [WP-1:0] dab, c, pcin;
  logic [WP-1:0] p, pcout;
  logic          co, cof;

  logic [4:0]    b_opmode;
  logic          b_cin;
  logic [WM-1:0] b_m;
  logic [WP-1:0] b_dab, b_c, b_pcin;
  logic [WP-1:0] b_p, b_pcout;
  logic          b_co, b_cof;

  always #5 clk = ~clk;

  dsp_post_adder_acc dut_reg (
    .clk(clk), .rstn(rstn), .CEP(cep), .CEOPMODE(ceop), .CECARRYIN(cecin),
    .OPMODE(opmode), .CARRYIN(carryin), .M(m), .DAB(dab), .C(c), .PCIN(pcin),
    .P(p), .PCOUT(pcout), .CARRYOUT(co), .CARRYOUTF(cof)
  );

  dsp_post_adder_acc #(.PREG(0), .OPMODEREG(0), .CARRYINREG(0)) dut_byp (
    .clk(clk), .rstn(rstn), .CEP(1'b0), .CEOPMODE(1'b0), .CECARRYIN(1'b0),
    .OPMODE(b_opmode), .CARRYIN(b_cin), .M(b_m), .DAB(b_dab), .C(b_c), .PCIN(b_pcin),
    .P(b_p), .PCOUT(b_pcout), .CARRYOUT(b_co), .CARRYOUTF(b_cof)
  );

  typedef struct {
    logic [4:0]    op;
    logic          cin;
    logic [WM-1:0] m;
    logic [WP-1:0] dab;
    logic [WP-1:0] c;
    logic [WP-1:0] pcin;
    logic          cep;
    logic [WP-1:0] ep;
    logic          eco;
  } vec_t;

  typedef struct {
    logic [WP-1:0] p;
    logic          co;
    int            tag;
  } exp_t;

  localparam int NV = 15;
  localparam int NB = 4;
  vec_t vecs[NV];
  vec_t bvecs[NB];
  exp_t q_reg[$];
  exp_t q_byp[$];

  int   total = 0;
  int   bad   = 0;
  logic in_valid  = 1'b0;
  logic out_valid = 1'b0;
  logic byp_valid = 1'b0;

  // With PREG = 1 the result appears one edge after the operands
  always @(posedge clk) out_valid <= in_valid;

  function automatic vec_t mk(input logic [4:0] op, input logic cin, input logic [WM-1:0] mv,
                              input logic [WP-1:0] dv, input logic [WP-1:0] cv,
                              input logic [WP-1:0] pv, input logic ce,
                              input logic [WP-1:0] ep, input logic eco);
    vec_t v;
    v.op = op; v.cin = cin; v.m = mv; v.dab = dv; v.c = cv; v.pcin = pv;
    v.cep = ce; v.ep = ep; v.eco = eco;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int tag,
                             input logic [WP:0] act, input logic [WP:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, tag, act, req);
    end
  endtask

  // Drive operands for step i and the control for step i+1 (control is registered)
  task automatic applyStimulus(input int i);
    exp_t e;
    m = vecs[i].m; dab = vecs[i].dab; c = vecs[i].c; pcin = vecs[i].pcin;
    cep = vecs[i].cep;
    in_valid = 1'b1;
    e.p = vecs[i].ep; e.co = vecs[i].eco; e.tag = i;
    q_reg.push_back(e);
    if (i + 1 < NV) begin
      opmode  = vecs[i+1].op;
      carryin = vecs[i+1].cin;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q_reg.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL reg_unexpected_output: got P=0x%0h, expected no output", p);
      end else begin
        e = q_reg.pop_front();
        checkOutput("P",         e.tag, {1'b0, p},     {1'b0, e.p});
        checkOutput("PCOUT",     e.tag, {1'b0, pcout}, {1'b0, e.p});
        checkOutput("CARRYOUT",  e.tag, {48'd0, co},   {48'd0, e.co});
        checkOutput("CARRYOUTF", e.tag, {48'd0, cof},  {48'd0, e.co});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (byp_valid) begin
      if (q_byp.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL byp_unexpected_output: got P=0x%0h, expected no output", b_p);
      end else begin
        e = q_byp.pop_front();
        checkOutput("bypass P",        e.tag, {1'b0, b_p},     {1'b0, e.p});
        checkOutput("bypass PCOUT",    e.tag, {1'b0, b_pcout}, {1'b0, e.p});
        checkOutput("bypass CARRYOUT", e.tag, {48'd0, b_co},   {48'd0, e.co});
        checkOutput("bypass CARRYOUTF",e.tag, {48'd0, b_cof},  {48'd0, e.co});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    // op = {sub, Z, X}
    vecs[0]  = mk(5'b0_00_01, 1'b0, 36'd5, '0, '0, '0, 1'b1, 48'd5, 1'b0);
    vecs[1]  = mk(5'b0_00_00, 1'b0, 36'd0, '0, '0, '0, 1'b1, 48'd0, 1'b0);
    vecs[2]  = mk(5'b0_10_01, 1'b0, 36'd3, '0, '0, '0, 1'b1, 48'd3, 1'b0);
    vecs[3]  = mk(5'b0_10_01, 1'b0, 36'd3, '0, '0, '0, 1'b1, 48'd6, 1'b0);
    vecs[4]  = mk(5'b0_10_01, 1'b0, 36'd3, '0, '0, '0, 1'b1, 48'd9, 1'b0);
    vecs[5]  = mk(5'b0_10_01, 1'b0, 36'd3, '0, '0, '0, 1'b1, 48'd12, 1'b0);
    vecs[6]  = mk(5'b0_10_01, 1'b0, 36'd3, '0, '0, '0, 1'b0, 48'd12, 1'b0);
    vecs[7]  = mk(5'b0_10_01, 1'b0, 36'd3, '0, '0, '0, 1'b0, 48'd12, 1'b0);
    vecs[8]  = mk(5'b0_11_11, 1'b0, 36'd0, 48'd1, 48'hFFFF_FFFF_FFFF, '0, 1'b1, 48'd0, 1'b1);
    vecs[9]  = mk(5'b1_11_11, 1'b1, 36'd0, 48'd7, 48'd5, '0, 1'b1, 48'hFFFF_FFFF_FFFD, 1'b1);
    vecs[10] = mk(5'b1_11_11, 1'b1, 36'd0, 48'd7, 48'd10, '0, 1'b1, 48'd2, 1'b0);
    vecs[11] = mk(5'b0_10_10, 1'b1, 36'd0, '0, '0, '0, 1'b1, 48'd5, 1'b0);
    vecs[12] = mk(5'b1_10_10, 1'b1, 36'd0, '0, '0, '0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
    vecs[13] = mk(5'b0_01_00, 1'b1, 36'd0, '0, '0, 48'hABC, 1'b1, 48'hABD, 1'b0);
    vecs[14] = mk(5'b0_00_11, 1'b0, 36'd0, 48'h1234, '0, '0, 1'b1, 48'h1234, 1'b0);

    bvecs[0] = mk(5'b0_01_00, 1'b1, 36'd0, '0, '0, 48'hABC, 1'b0, 48'hABD, 1'b0);
    bvecs[1] = mk(5'b1_11_01, 1'b0, 36'd1, '0, 48'h64, '0, 1'b0, 48'h63, 1'b0);
    bvecs[2] = mk(5'b0_01_11, 1'b0, 36'd0, 48'hFFFF_FFFF_FFFF, '0, 48'd2, 1'b0, 48'd1, 1'b1);
    bvecs[3] = mk(5'b1_11_00, 1'b1, 36'd0, '0, 48'd0, '0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1);

    rstn = 1'b0; cep = 1'b0; ceop = 1'b1; cecin = 1'b1;
    opmode = '0; carryin = 1'b0; m = '0; dab = '0; c = '0; pcin = '0;
    b_opmode = '0; b_cin = 1'b0; b_m = '0; b_dab = '0; b_c = '0; b_pcin = '0;

    #1;
    checkOutput("reset P",        0, {1'b0, p},   49'd0);
    checkOutput("reset CARRYOUT", 0, {48'd0, co}, 49'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    @(negedge clk);
    opmode = vecs[0].op; carryin = vecs[0].cin; cep = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(i);
    end
    @(negedge clk);
    in_valid = 1'b0; cep = 1'b0;
    #1;
    for (int k = 0; k < 10 && q_reg.size() != 0; k++) @(negedge clk);
    if (q_reg.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL reg_drain: got %0d pending results, expected 0", q_reg.size());
    end

    // Asynchronous reset while P holds 0x1234, away from any clock edge
    #2 rstn = 1'b0;
    #1;
    checkOutput("async reset P",         1, {1'b0, p},     49'd0);
    checkOutput("async reset PCOUT",     1, {1'b0, pcout}, 49'd0);
    checkOutput("async reset CARRYOUT",  1, {48'd0, co},   49'd0);
    @(posedge clk); #1;
    checkOutput("reset hold P",          2, {1'b0, p},     49'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Bypassed instance: result follows inputs within the cycle; the last
    // vector runs with rstn low, which must not affect a bypassed path
    for (int i = 0; i < NB; i++) begin
      @(posedge clk); #1;
      b_opmode = bvecs[i].op; b_cin = bvecs[i].cin; b_m = bvecs[i].m;
      b_dab = bvecs[i].dab; b_c = bvecs[i].c; b_pcin = bvecs[i].pcin;
      if (i == NB - 1) rstn = 1'b0;
      e.p = bvecs[i].ep; e.co = bvecs[i].eco; e.tag = i;
      q_byp.push_back(e);
      byp_valid = 1'b1;
    end
    @(posedge clk); #1;
    byp_valid = 1'b0;
    rstn = 1'b1;
    if (q_byp.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL byp_drain: got %0d pending results, expected 0", q_byp.size());
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1 slice.
- Consumes the registered multiplier product M, the concatenated D:A:B bus, C and PCIN.
- Selects X/Z operands per OPMODE, computes Z ± (X + CIN), and drives the P register, PCOUT cascade and carry-out.
- Sits directly downstream of the M/C/D:A:B pipeline register+bypass stages.

Parameters:
- PREG, 1, 1 = P/CARRYOUT registered; 0 = combinational bypass.
- OPMODEREG, 1, 1 = OPMODE[7,3:0] registered (aligned with M pipeline); 0 = bypass.
- CARRYINREG, 1, 1 = CIN registered; 0 = bypass.
- WIDTH_P, 48, post-adder/P width.
- WIDTH_M, 36, multiplier product width.

Ports:
- clk, in, 1, slice clock, rising edge.
- rstn, in, 1, asynchronous active-low reset of every register in this block.
- CEP, in, 1, clock enable for the P and CARRYOUT registers.
- CEOPMODE, in, 1, clock enable for the OPMODE register.
- CECARRYIN, in, 1, clock enable for the CIN register.
- OPMODE, in, 5, {bit7, bit3:2 = Z sel, bit1:0 = X sel}; packed as [4] = sub, [3:2] = Z, [1:0] = X.
- CARRYIN, in, 1, post-adder carry-in (pre-selected upstream).
- M, in, WIDTH_M, multiplier product.
- DAB, in, WIDTH_P, {D[11:0], A[17:0], B[17:0]}.
- C, in, WIDTH_P, C operand.
- PCIN, in, WIDTH_P, cascade input from the previous slice.
- P, out, WIDTH_P, result.
- PCOUT, out, WIDTH_P, cascade output; always equal to P.
- CARRYOUT, out, 1, post-adder carry/borrow.
- CARRYOUTF, out, 1, fabric copy of CARRYOUT.

Behaviour:
- Reset (rstn = 0, asynchronous): P = 0, CARRYOUT = 0, OPMODE register = 0, CIN register = 0. Held until rstn deasserts.
- Reset deassertion takes effect on the next clk edge. Reset mid-accumulation discards the accumulated value; no restore.
- Each register loads only when its CE = 1; otherwise it holds.
- When a register's parameter is 0, its output follows its input combinationally, and CE/rstn have no effect on it.
- X mux:
  - 00 → 0
  - 01 → M zero-extended to WIDTH_P
  - 10 → P feedback
  - 11 → DAB
- Z mux:
  - 00 → 0
  - 01 → PCIN
  - 10 → P feedback
  - 11 → C
- Arithmetic, computed at WIDTH_P+1 bits unsigned:
  - sub = 0: R = Z + X + CIN.
  - sub = 1: R = Z − (X + CIN).
  - P ← R[WIDTH_P−1:0]; CARRYOUT ← R[WIDTH_P].
  - On subtraction, CARRYOUT is the borrow (1 when X + CIN > Z).
  - Wrap-around is modulo 2^48; there is no saturation.
- Latency: with PREG = 1, P and CARRYOUT update at the clk edge after the operands and the selected OPMODE/CIN are valid.
  - OPMODEREG and CARRYINREG each add one cycle to their control path only. Upstream aligns these paths with the M register.
- Feedback (X = 10 or Z = 10) is legal only with PREG = 1.
  - With PREG = 0 the feedback leg drives 0, and a simulation assertion fires.
- Simultaneous CEP = 1 and feedback: the new P uses the pre-edge P (standard register semantics).
- X = Z = 10 with sub = 0 gives 2·P + CIN. With sub = 1 it gives −CIN mod 2^48.
- PCOUT and CARRYOUTF are wire copies of P and CARRYOUT; no extra latency.

Decomposition:
- Shared package dsp48a1_pkg:
  - X_ZERO/X_M/X_P/X_DAB and Z_ZERO/Z_PCIN/Z_P/Z_C select constants.
  - OPMODE bit-position constants.
  - WIDTH_P/WIDTH_M defaults.
- Sub-module post_add_core: purely combinational X/Z muxes plus the (WIDTH_P+1)-bit add/subtract.
- The top level instantiates post_add_core and builds the OPMODE/CIN/P registers with the existing register+bypass cell, using RST_TYPE = ASYNC.

Test Plan:
- Reset: drive rstn = 0 mid-run with P = 0x0000_0000_1234 → P, CARRYOUT and PCOUT go to 0 immediately, before the next clk edge, and stay 0 until release.
- Multiply-pass: OPMODE X = 01, Z = 00, M = 0x0_0000_0005, CIN = 0 → P = 5 one cycle after the aligned inputs; CARRYOUT = 0.
- Accumulate: X = 01, Z = 10, M = 3 for 4 cycles from P = 0 → P = 3, 6, 9, 12. Then CEP = 0 for 2 cycles → P holds at 12.
- Wrap/carry: Z = 11, C = 0xFFFF_FFFF_FFFF, X = 11, DAB = 1, CIN = 0 → P = 0, CARRYOUT = 1, CARRYOUTF = 1.
- Subtract/borrow: sub = 1, Z = C = 5, X = DAB = 7, CIN = 1 → P = 0xFFFF_FFFF_FFFD, CARRYOUT = 1. With C = 10 → P = 2, CARRYOUT = 0.
- Bypass: PREG = 0, OPMODEREG = 0, CARRYINREG = 0, Z = 01, PCIN = 0xABC, CIN = 1 → P = 0xABD in the same cycle. Selecting X = 10 fires the feedback assertion.
